id_stage_pipe: RTL and testbench
================================

Name: id_stage_pipe

Overview:
- Parametrised next-generation instruction-decode stage for the in-order CPU pipeline.
- Decodes the instruction and reads two register-file ports from an internal register file.
- Registers the ID/EX pipeline boundary with a valid bit.
- Detects load-use hazards, accepts flush and downstream-stall controls, and latches a sticky halt.

Parameters:
- DATA_W, 16, register and datapath width; must be >= 16.
- REG_AW, 4, register address width; NREG = 2**REG_AW; INSTR_W = 4 + 3*REG_AW.

Ports:
- i_clk  in  1  clock, rising-edge.
- i_nRst  in  1  reset, synchronous, active-low.
- i_instr  in  INSTR_W  instruction from IF; fields op=[top 4], rd, rs, rt (REG_AW each, MSB to LSB).
- i_pc  in  DATA_W  PC+1 of i_instr.
- i_valid  in  1  i_instr is a real instruction.
- i_flush  in  1  kill the instruction currently in ID.
- i_exStall  in  1  EX cannot accept; hold the ID/EX register.
- i_wrEn  in  1  writeback enable.
- i_wrReg  in  REG_AW  writeback address.
- i_wrData  in  DATA_W  writeback data.
- o_stall  out  1  combinational; IF must hold i_instr/i_pc.
- o_valid  out  1  ID/EX slot holds a real instruction.
- o_pc  out  DATA_W  registered i_pc.
- o_port0, o_port1  out  DATA_W  registered rs and rt read data.
- o_sext  out  DATA_W  registered sign-extended {rs,rt} immediate.
- o_wrReg  out  REG_AW  registered destination (rd).
- o_wrEn  out  1  registered register-write enable.
- o_aluOp  out  4  registered opcode for ALU ops.
- o_memRd, o_memWr, o_mem2reg, o_aluSrc, o_sawBr, o_sawJ  out  1 each  registered controls.
- o_hlt  out  1  sticky halt.

Behaviour:
- Opcode map:
  - 0x0-0x7: ALU R-type, rd <= rs op rt. wrEn=1, aluOp=op, uses rs and rt.
  - 0x8: LW. memRd=1, mem2reg=1, aluSrc=1, wrEn=1, uses rs.
  - 0x9: SW. memWr=1, aluSrc=1, uses rs and rt (rt is the data).
  - 0xA: LLI. aluSrc=1, wrEn=1, aluOp=0, port0 forced 0.
  - 0xC: branch. sawBr=1, uses rs and rt.
  - 0xD: jump. sawJ=1.
  - 0xF: HLT.
  - Others: NOP, all controls 0.
- Register file: NREG x DATA_W. Register 0 reads 0; writes to register 0 are ignored. Writes commit at the clock edge when i_wrEn=1.
- Load-use hazard (haz), all terms required:
  - i_valid, and o_valid & o_memRd;
  - o_wrReg != 0;
  - (uses rs & rs == o_wrReg) or (uses rt & rt == o_wrReg).
- Priority at each edge, highest first:
  1. Reset.
  2. i_exStall: hold every output.
  3. i_flush: o_valid <= 0, all registered controls <= 0.
  4. haz: insert bubble, same as flush.
  5. Normal: load decode results; o_valid <= i_valid & ~o_hlt.
- When o_valid would be 0, all registered controls are loaded as 0 (bubble).
- o_stall = i_exStall | (haz & ~i_flush) | o_hlt.
- Latency: one cycle from i_instr accepted to o_* valid. A load-use pair costs exactly one bubble.
- Halt:
  - o_hlt <= 1 at the edge that loads a valid HLT into ID/EX.
  - Cleared only by reset. While set, o_valid stays 0.
  - A flushed HLT never sets o_hlt.
- Reset (i_nRst=0 at edge): all outputs 0, o_hlt=0, all registers cleared to 0. i_wrEn is ignored that cycle.
- Reset mid-stall or mid-hazard: reset wins, and the next cycle starts clean.
- o_sext is sign extension of the 2*REG_AW-bit immediate to DATA_W.

Optional Feature:
- WB_BYPASS_EN defined: same-cycle bypass. If i_wrEn & i_wrReg != 0 & i_wrReg matches rs (or rt), the corresponding read data is i_wrData in the same cycle.
- WB_BYPASS_EN undefined: the read returns the pre-write contents, and the written value is visible from the next cycle.

Test Plan:
- Reset then write r3=0x1234; ADD r5,r3,r3 (0x0533) -> next cycle o_valid=1, o_port0=o_port1=0x1234, o_wrReg=5, o_wrEn=1, o_aluOp=0.
- LW r2 (0x8210) followed by ADD r4,r2,r1 (0x0421) -> o_stall=1 for one cycle, one bubble (o_valid=0), then ADD issues. Same with rd=r0 -> no stall.
- i_exStall=1 for 3 cycles with a valid instruction -> all o_* unchanged and o_stall=1. i_flush on the following cycle -> o_valid=0.
- i_wrEn=1, i_wrReg=7, i_wrData=0xBEEF while decoding SUB rX,r7,r0 -> o_port0=0xBEEF with WB_BYPASS_EN, previous r7 value without it. A write to r0 always reads back 0.
- LLI r1,0xF0 (0xA1F0) -> o_sext=0xFFF0, o_aluSrc=1, o_port0=0.
- HLT (0xF000) then further valid instructions -> o_hlt=1 sticky and o_valid=0 afterward. Assert i_nRst=0 -> o_hlt=0.

Source files
------------

// File: rtl/id_stage_pipe.sv
// ============================================================================
// Module  : id_stage_pipe
// Brief   : Instruction-decode stage with internal register file, load-use
//           hazard detection and a registered ID/EX boundary.
//           Optional macro WB_BYPASS_EN: same-cycle writeback-to-read bypass.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module id_stage_pipe #(
    parameter int DATA_W  = 16,
    parameter int REG_AW  = 4,
    localparam int NREG    = 2**REG_AW,
    localparam int INSTR_W = 4 + 3*REG_AW
) (
    input  logic                i_clk,
    input  logic                i_nRst,
    input  logic [INSTR_W-1:0]  i_instr,
    input  logic [DATA_W-1:0]   i_pc,
    input  logic                i_valid,
    input  logic                i_flush,
    input  logic                i_exStall,
    input  logic                i_wrEn,
    input  logic [REG_AW-1:0]   i_wrReg,
    input  logic [DATA_W-1:0]   i_wrData,
    output logic                o_stall,
    output logic                o_valid,
    output logic [DATA_W-1:0]   o_pc,
    output logic [DATA_W-1:0]   o_port0,
    output logic [DATA_W-1:0]   o_port1,
    output logic [DATA_W-1:0]   o_sext,
    output logic [REG_AW-1:0]   o_wrReg,
    output logic                o_wrEn,
    output logic [3:0]          o_aluOp,
    output logic                o_memRd,
    output logic                o_memWr,
    output logic                o_mem2reg,
    output logic                o_aluSrc,
    output logic                o_sawBr,
    output logic                o_sawJ,
    output logic                o_hlt
);

    localparam logic [3:0] OP_LW  = 4'h8;
    localparam logic [3:0] OP_SW  = 4'h9;
    localparam logic [3:0] OP_LLI = 4'hA;
    localparam logic [3:0] OP_BR  = 4'hC;
    localparam logic [3:0] OP_J   = 4'hD;
    localparam logic [3:0] OP_HLT = 4'hF;

    logic [3:0]          op;
    logic [REG_AW-1:0]   rd;
    logic [REG_AW-1:0]   rs;
    logic [REG_AW-1:0]   rt;
    logic [2*REG_AW-1:0] imm;

    assign op  = i_instr[INSTR_W-1 -: 4];
    assign rd  = i_instr[3*REG_AW-1 -: REG_AW];
    assign rs  = i_instr[2*REG_AW-1 -: REG_AW];
    assign rt  = i_instr[REG_AW-1:0];
    assign imm = i_instr[2*REG_AW-1:0];

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic       dec_wr_en;
    logic [3:0] dec_alu_op;
    logic       dec_mem_rd;
    logic       dec_mem_wr;
    logic       dec_mem2reg;
    logic       dec_alu_src;
    logic       dec_saw_br;
    logic       dec_saw_j;
    logic       dec_hlt;
    logic       dec_zero_p0;
    logic       uses_rs;
    logic       uses_rt;

    always_comb begin
        dec_wr_en   = 1'b0;
        dec_alu_op  = 4'h0;
        dec_mem_rd  = 1'b0;
        dec_mem_wr  = 1'b0;
        dec_mem2reg = 1'b0;
        dec_alu_src = 1'b0;
        dec_saw_br  = 1'b0;
        dec_saw_j   = 1'b0;
        dec_hlt     = 1'b0;
        dec_zero_p0 = 1'b0;
        uses_rs     = 1'b0;
        uses_rt     = 1'b0;
        if (!op[3]) begin
            dec_wr_en  = 1'b1;
            dec_alu_op = op;
            uses_rs    = 1'b1;
            uses_rt    = 1'b1;
        end else begin
            case (op)
                OP_LW: begin
                    dec_mem_rd  = 1'b1;
                    dec_mem2reg = 1'b1;
                    dec_alu_src = 1'b1;
                    dec_wr_en   = 1'b1;
                    uses_rs     = 1'b1;
                end
                OP_SW: begin
                    dec_mem_wr  = 1'b1;
                    dec_alu_src = 1'b1;
                    uses_rs     = 1'b1;
                    uses_rt     = 1'b1;
                end
                OP_LLI: begin
                    dec_alu_src = 1'b1;
                    dec_wr_en   = 1'b1;
                    dec_zero_p0 = 1'b1;
                end
                OP_BR: begin
                    dec_saw_br = 1'b1;
                    uses_rs    = 1'b1;
                    uses_rt    = 1'b1;
                end
                OP_J:    dec_saw_j = 1'b1;
                OP_HLT:  dec_hlt   = 1'b1;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rf [NREG];
    logic [DATA_W-1:0] rd_rs;
    logic [DATA_W-1:0] rd_rt;
    logic [DATA_W-1:0] port0_d;

    always_ff @(posedge i_clk) begin
        if (!i_nRst) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (i_wrEn && (i_wrReg != '0)) begin
            rf[i_wrReg] <= i_wrData;
        end
    end

`ifdef WB_BYPASS_EN
    always_comb begin
        rd_rs = (rs == '0) ? '0 : rf[rs];
        rd_rt = (rt == '0) ? '0 : rf[rt];
        if (i_wrEn && (i_wrReg != '0) && (i_wrReg == rs)) rd_rs = i_wrData;
        if (i_wrEn && (i_wrReg != '0) && (i_wrReg == rt)) rd_rt = i_wrData;
    end
`else
    always_comb begin
        rd_rs = (rs == '0) ? '0 : rf[rs];
        rd_rt = (rt == '0) ? '0 : rf[rt];
    end
`endif

    assign port0_d = dec_zero_p0 ? '0 : rd_rs;

    // ------------------------------------------------------------------
    // Hazard and stall
    // ------------------------------------------------------------------
    logic haz;
    logic load_valid;

    assign haz = i_valid && o_valid && o_memRd && (o_wrReg != '0) &&
                 ((uses_rs && (rs == o_wrReg)) || (uses_rt && (rt == o_wrReg)));

    assign o_stall    = i_exStall | (haz & ~i_flush) | o_hlt;
    assign load_valid = i_valid & ~o_hlt;

    // ------------------------------------------------------------------
    // ID/EX register; a bubble clears the whole slot
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_nRst || (!i_exStall && (i_flush || haz || !load_valid))) begin
            o_valid   <= 1'b0;
            o_pc      <= '0;
            o_port0   <= '0;
            o_port1   <= '0;
            o_sext    <= '0;
            o_wrReg   <= '0;
            o_wrEn    <= 1'b0;
            o_aluOp   <= 4'h0;
            o_memRd   <= 1'b0;
            o_memWr   <= 1'b0;
            o_mem2reg <= 1'b0;
            o_aluSrc  <= 1'b0;
            o_sawBr   <= 1'b0;
            o_sawJ    <= 1'b0;
        end else if (!i_exStall) begin
            o_valid   <= 1'b1;
            o_pc      <= i_pc;
            o_port0   <= port0_d;
            o_port1   <= rd_rt;
            o_sext    <= {{(DATA_W-2*REG_AW){imm[2*REG_AW-1]}}, imm};
            o_wrReg   <= rd;
            o_wrEn    <= dec_wr_en;
            o_aluOp   <= dec_alu_op;
            o_memRd   <= dec_mem_rd;
            o_memWr   <= dec_mem_wr;
            o_mem2reg <= dec_mem2reg;
            o_aluSrc  <= dec_alu_src;
            o_sawBr   <= dec_saw_br;
            o_sawJ    <= dec_saw_j;
        end
    end

    // Halt sets only when a valid HLT actually lands in the ID/EX slot.
    always_ff @(posedge i_clk) begin
        if (!i_nRst) begin
            o_hlt <= 1'b0;
        end else if (!i_exStall && !i_flush && !haz && load_valid && dec_hlt) begin
            o_hlt <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_id_stage_pipe.sv
// ============================================================================
// Module  : tb_id_stage_pipe
// Brief   : Directed scoreboard bench for id_stage_pipe.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_stage_pipe;

    logic        clk;
    logic        nrst;
    logic [15:0] instr;
    logic [15:0] pc;
    logic        valid;
    logic        flush;
    logic        ex_stall;
    logic        wr_en;
    logic [3:0]  wr_reg;
    logic [15:0] wr_data;
    logic        stall;
    logic        o_valid;
    logic [15:0] o_pc;
    logic [15:0] o_port0;
    logic [15:0] o_port1;
    logic [15:0] o_sext;
    logic [3:0]  o_wr_reg;
    logic        o_wr_en;
    logic [3:0]  o_alu_op;
    logic        o_mem_rd;
    logic        o_mem_wr;
    logic        o_mem2reg;
    logic        o_alu_src;
    logic        o_saw_br;
    logic        o_saw_j;
    logic        o_hlt;

    id_stage_pipe #(.DATA_W(16), .REG_AW(4)) dut (
        .i_clk     (clk),
        .i_nRst    (nrst),
        .i_instr   (instr),
        .i_pc      (pc),
        .i_valid   (valid),
        .i_flush   (flush),
        .i_exStall (ex_stall),
        .i_wrEn    (wr_en),
        .i_wrReg   (wr_reg),
        .i_wrData  (wr_data),
        .o_stall   (stall),
        .o_valid   (o_valid),
        .o_pc      (o_pc),
        .o_port0   (o_port0),
        .o_port1   (o_port1),
        .o_sext    (o_sext),
        .o_wrReg   (o_wr_reg),
        .o_wrEn    (o_wr_en),
        .o_aluOp   (o_alu_op),
        .o_memRd   (o_mem_rd),
        .o_memWr   (o_mem_wr),
        .o_mem2reg (o_mem2reg),
        .o_aluSrc  (o_alu_src),
        .o_sawBr   (o_saw_br),
        .o_sawJ    (o_saw_j),
        .o_hlt     (o_hlt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctl = {wrEn, memRd, memWr, mem2reg, aluSrc, sawBr, sawJ}
    typedef struct {
        string       name;
        logic        stall;
        logic        valid;
        logic        hlt;
        logic [15:0] pc;
        logic [15:0] p0;
        logic [15:0] p1;
        logic [15:0] sext;
        logic [3:0]  wr_reg;
        logic [3:0]  alu_op;
        logic [6:0]  ctl;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

`ifdef WB_BYPASS_EN
    localparam logic [15:0] BYP_R7 = 16'hBEEF;
`else
    localparam logic [15:0] BYP_R7 = 16'h7777;
`endif

    function automatic exp_t ev(string nm, logic st, logic hl, logic [15:0] p,
                                logic [15:0] a, logic [15:0] b, logic [15:0] sx,
                                logic [3:0] wr, logic [3:0] op, logic [6:0] c);
        exp_t e;
        e.name = nm; e.stall = st; e.valid = 1'b1; e.hlt = hl;
        e.pc = p; e.p0 = a; e.p1 = b; e.sext = sx;
        e.wr_reg = wr; e.alu_op = op; e.ctl = c;
        return e;
    endfunction

    function automatic exp_t eb(string nm, logic st, logic hl);
        exp_t e;
        e = ev(nm, st, hl, 16'h0, 16'h0, 16'h0, 16'h0, 4'h0, 4'h0, 7'h0);
        e.valid = 1'b0;
        return e;
    endfunction

    task automatic cmp(string nm, string field, logic [15:0] act, logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s: got %h expected %h", nm, field, act, req);
        end
    endtask

    // Monitor: each sampled cycle pops one expectation of the visible state.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp(e.name, "stall", {15'h0, stall},   {15'h0, e.stall});
            cmp(e.name, "valid", {15'h0, o_valid}, {15'h0, e.valid});
            cmp(e.name, "hlt",   {15'h0, o_hlt},   {15'h0, e.hlt});
            cmp(e.name, "pc",    o_pc,    e.pc);
            cmp(e.name, "port0", o_port0, e.p0);
            cmp(e.name, "port1", o_port1, e.p1);
            cmp(e.name, "sext",  o_sext,  e.sext);
            cmp(e.name, "wrReg", {12'h0, o_wr_reg}, {12'h0, e.wr_reg});
            cmp(e.name, "aluOp", {12'h0, o_alu_op}, {12'h0, e.alu_op});
            cmp(e.name, "ctl", {9'h0, o_wr_en, o_mem_rd, o_mem_wr, o_mem2reg,
                                o_alu_src, o_saw_br, o_saw_j}, {9'h0, e.ctl});
        end
    end

    task automatic step(input logic rst_n, input logic [15:0] ins, input logic [15:0] p,
                        input logic v, input logic fl, input logic xs,
                        input logic we, input logic [3:0] wr, input logic [15:0] wd,
                        input exp_t e);
        @(posedge clk);
        #1;
        nrst = rst_n; instr = ins; pc = p; valid = v; flush = fl; ex_stall = xs;
        wr_en = we; wr_reg = wr; wr_data = wd;
        exp_q.push_back(e);
    endtask

    localparam logic [6:0] C_ALU = 7'b1000000;
    localparam logic [6:0] C_LW  = 7'b1101100;
    localparam logic [6:0] C_LLI = 7'b1000100;

    initial begin
        nrst = 1'b0; instr = '0; pc = '0; valid = 1'b0; flush = 1'b0;
        ex_stall = 1'b0; wr_en = 1'b1; wr_reg = 4'd3; wr_data = 16'hDEAD;

        // Each step: inputs for the cycle, expectation of what is visible in it.
        step(0, 16'h0000, 16'h00, 0, 0, 0, 1, 4'd5, 16'h5555, eb("reset", 0, 0));
        step(1, 16'h0000, 16'h00, 0, 0, 0, 1, 4'd3, 16'h1234, eb("reset_hold", 0, 0));
        step(1, 16'h0533, 16'h10, 1, 0, 0, 0, 4'd0, 16'h0000, eb("idle0", 0, 0));
        step(1, 16'h0000, 16'h00, 0, 0, 0, 1, 4'd1, 16'h0011,
             ev("add_r5", 0, 0, 16'h10, 16'h1234, 16'h1234, 16'h0033, 4'd5, 4'd0, C_ALU));
        step(1, 16'h8210, 16'h20, 1, 0, 0, 0, 4'd0, 16'h0000, eb("idle1", 0, 0));
        step(1, 16'h0421, 16'h21, 1, 0, 0, 1, 4'd2, 16'h0022,
             ev("lw_r2", 1, 0, 16'h20, 16'h0011, 16'h0000, 16'h0010, 4'd2, 4'd0, C_LW));
        step(1, 16'h0421, 16'h21, 1, 0, 0, 0, 4'd0, 16'h0000, eb("bubble", 0, 0));
        step(1, 16'h8010, 16'h30, 1, 0, 0, 0, 4'd0, 16'h0000,
             ev("add_r4", 0, 0, 16'h21, 16'h0022, 16'h0011, 16'h0021, 4'd4, 4'd0, C_ALU));
        step(1, 16'h0401, 16'h31, 1, 0, 0, 0, 4'd0, 16'h0000,
             ev("lw_r0", 0, 0, 16'h30, 16'h0011, 16'h0000, 16'h0010, 4'd0, 4'd0, C_LW));
        step(1, 16'h1612, 16'h40, 1, 0, 0, 0, 4'd0, 16'h0000,
             ev("add_r0", 0, 0, 16'h31, 16'h0000, 16'h0011, 16'h0001, 4'd4, 4'd0, C_ALU));
        for (int i = 0; i < 3; i++)
            step(1, 16'h0533, 16'h41, 1, 0, 1, 0, 4'd0, 16'h0000,
                 ev("exstall", 1, 0, 16'h40, 16'h0011, 16'h0022, 16'h0012, 4'd6, 4'd1, C_ALU));
        step(1, 16'h0533, 16'h41, 1, 1, 0, 1, 4'd0, 16'h5555,
             ev("sub_held", 0, 0, 16'h40, 16'h0011, 16'h0022, 16'h0012, 4'd6, 4'd1, C_ALU));
        step(1, 16'h0000, 16'h00, 0, 0, 0, 1, 4'd7, 16'h7777, eb("flushed", 0, 0));
        step(1, 16'h1970, 16'h50, 1, 0, 0, 1, 4'd7, 16'hBEEF, eb("idle2", 0, 0));
        step(1, 16'h0A07, 16'h51, 1, 0, 0, 1, 4'd0, 16'hAAAA,
             ev("sub_byp", 0, 0, 16'h50, BYP_R7, 16'h0000, 16'h0070, 4'd9, 4'd1, C_ALU));
        step(1, 16'h0000, 16'h00, 0, 0, 0, 0, 4'd0, 16'h0000,
             ev("add_r0rd", 0, 0, 16'h51, 16'h0000, 16'hBEEF, 16'h0007, 4'd10, 4'd0, C_ALU));
        step(1, 16'hA1F0, 16'h60, 1, 0, 0, 0, 4'd0, 16'h0000, eb("idle3", 0, 0));
        step(1, 16'hF000, 16'h61, 1, 0, 0, 0, 4'd0, 16'h0000,
             ev("lli", 0, 0, 16'h60, 16'h0000, 16'h0000, 16'hFFF0, 4'd1, 4'd0, C_LLI));
        step(1, 16'h0533, 16'h62, 1, 0, 0, 0, 4'd0, 16'h0000,
             ev("hlt", 1, 1, 16'h61, 16'h0000, 16'h0000, 16'h0000, 4'd0, 4'd0, 7'h0));
        step(1, 16'h0533, 16'h62, 1, 0, 0, 0, 4'd0, 16'h0000, eb("hlt_sticky", 1, 1));
        step(0, 16'h0533, 16'h62, 1, 0, 0, 0, 4'd0, 16'h0000, eb("hlt_sticky2", 1, 1));
        step(1, 16'h0000, 16'h00, 0, 0, 0, 0, 4'd0, 16'h0000, eb("hlt_reset", 0, 0));
        step(1, 16'hF000, 16'h70, 1, 1, 0, 0, 4'd0, 16'h0000, eb("idle4", 0, 0));
        step(1, 16'h0000, 16'h00, 0, 0, 0, 0, 4'd0, 16'h0000, eb("flush_hlt", 0, 0));
        step(1, 16'h0000, 16'h00, 0, 0, 0, 0, 4'd0, 16'h0000, eb("idle5", 0, 0));

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
